// File: rtl/conv_layer_row_sequencer.sv
// ---------------------------------------------------------------------------
// conv_layer_row_sequencer
//
// Walks the conv layer input interface through one image frame. The first
// KERNEL_SIZE rows are preloaded, then every output row costs one window
// SHIFT followed by one further row LOAD (the last SHIFT is not followed by
// a LOAD). Each command is held for a single cycle and the sequencer then
// waits, with the command bus back at CMD_IDLE, for the matching ack code.
// Wrong ack codes and stalled waits park the sequencer in ERROR with a
// sticky error flag.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active-high
//   start        one-cycle frame request, honoured in IDLE and ERROR
//   abort        synchronous abort, returns to IDLE from any state
//   iface_ack    ack code from the interface (IDLE/SHIFT_FIN/LOAD_FIN/illegal)
//   iface_enable interface enable, high while a frame is being sequenced
//   iface_cmd    command to the interface (IDLE/SHIFT/LOAD)
//   busy         frame in progress
//   row_done     one-cycle pulse per completed output row
//   out_row_idx  index of the most recently completed output row
//   frame_done   one-cycle pulse after the final output row
//   error        sticky fault flag, cleared by start or rst
// ---------------------------------------------------------------------------
module conv_layer_row_sequencer #(
  parameter int KERNEL_SIZE    = 2,
  parameter int IMAGE_SIZE     = 8,
  parameter int ROW_CNT_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               iface_ack,
  output logic                     iface_enable,
  output logic [1:0]               iface_cmd,
  output logic                     busy,
  output logic                     row_done,
  output logic [ROW_CNT_WIDTH-1:0] out_row_idx,
  output logic                     frame_done,
  output logic                     error
);

  localparam logic [1:0] ACK_IDLE      = 2'd0;
  localparam logic [1:0] ACK_SHIFT_FIN = 2'd1;
  localparam logic [1:0] ACK_LOAD_FIN  = 2'd2;
  localparam logic [1:0] CMD_IDLE      = 2'd0;
  localparam logic [1:0] CMD_SHIFT     = 2'd1;
  localparam logic [1:0] CMD_LOAD      = 2'd2;

  localparam logic [ROW_CNT_WIDTH-1:0] LP_ROW_ZERO = ROW_CNT_WIDTH'(0);
  localparam logic [ROW_CNT_WIDTH-1:0] LP_ROW_ONE  = ROW_CNT_WIDTH'(1);
  localparam logic [ROW_CNT_WIDTH-1:0] LP_KERNEL   = ROW_CNT_WIDTH'(KERNEL_SIZE);
  localparam logic [ROW_CNT_WIDTH-1:0] LP_IMAGE    = ROW_CNT_WIDTH'(IMAGE_SIZE);
  localparam logic [ROW_CNT_WIDTH-1:0] LP_OUT_ROWS = ROW_CNT_WIDTH'(IMAGE_SIZE - KERNEL_SIZE + 1);

  localparam logic [TIMEOUT_WIDTH-1:0] LP_WD_ZERO = TIMEOUT_WIDTH'(0);
  localparam logic [TIMEOUT_WIDTH-1:0] LP_WD_ONE  = TIMEOUT_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] LP_WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_REQ   = 3'd1,
    ST_LOAD_WAIT  = 3'd2,
    ST_SHIFT_REQ  = 3'd3,
    ST_SHIFT_WAIT = 3'd4,
    ST_DONE       = 3'd5,
    ST_ERROR      = 3'd6
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ROW_CNT_WIDTH-1:0] r_load_cnt;
  logic [ROW_CNT_WIDTH-1:0] w_load_cnt_nxt;
  logic [ROW_CNT_WIDTH-1:0] r_out_cnt;
  logic [ROW_CNT_WIDTH-1:0] w_out_cnt_nxt;
  logic [ROW_CNT_WIDTH-1:0] r_out_row_idx;
  logic [ROW_CNT_WIDTH-1:0] w_out_row_idx_nxt;
  logic [ROW_CNT_WIDTH-1:0] w_load_inc;
  logic [ROW_CNT_WIDTH-1:0] w_out_inc;
  logic [TIMEOUT_WIDTH-1:0] r_wdog;
  logic [TIMEOUT_WIDTH-1:0] w_wdog_nxt;
  logic                     r_error;
  logic                     w_error_nxt;
  logic                     w_row_done;
  logic                     r_row_done;
  logic                     r_iface_enable;
  logic                     w_iface_enable_nxt;
  logic [1:0]               r_iface_cmd;
  logic [1:0]               w_iface_cmd_nxt;
  logic                     r_busy;
  logic                     w_busy_nxt;
  logic                     r_frame_done;
  logic                     w_frame_done_nxt;

  // Row counters saturate rather than wrap.
  assign w_load_inc = (r_load_cnt == LP_IMAGE)    ? r_load_cnt : r_load_cnt + LP_ROW_ONE;
  assign w_out_inc  = (r_out_cnt  == LP_OUT_ROWS) ? r_out_cnt  : r_out_cnt  + LP_ROW_ONE;

  // Next-state, counter and fault logic
  always_comb begin
    w_state_nxt       = r_state;
    w_load_cnt_nxt    = r_load_cnt;
    w_out_cnt_nxt     = r_out_cnt;
    w_out_row_idx_nxt = r_out_row_idx;
    w_wdog_nxt        = r_wdog;
    w_error_nxt       = r_error;
    w_row_done        = 1'b0;

    if (abort) begin
      // Abort outranks start and acks; error is left as it was.
      w_state_nxt    = ST_IDLE;
      w_load_cnt_nxt = LP_ROW_ZERO;
      w_out_cnt_nxt  = LP_ROW_ZERO;
      w_wdog_nxt     = LP_WD_ZERO;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            w_state_nxt    = ST_LOAD_REQ;
            w_load_cnt_nxt = LP_ROW_ZERO;
            w_out_cnt_nxt  = LP_ROW_ZERO;
            w_wdog_nxt     = LP_WD_ZERO;
            w_error_nxt    = 1'b0;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_LOAD_REQ: begin
          w_wdog_nxt  = LP_WD_ZERO;
          w_state_nxt = ST_LOAD_WAIT;
        end
        ST_LOAD_WAIT: begin
          if (iface_ack == ACK_LOAD_FIN) begin
            w_load_cnt_nxt = w_load_inc;
            // Preload the first KERNEL_SIZE rows before any window shift.
            if (w_load_inc < LP_KERNEL) begin
              w_state_nxt = ST_LOAD_REQ;
            end else begin
              w_state_nxt = ST_SHIFT_REQ;
            end
          end else if (iface_ack != ACK_IDLE) begin
            w_error_nxt = 1'b1;
            w_state_nxt = ST_ERROR;
          end else if (r_wdog >= LP_WD_LAST) begin
            w_error_nxt = 1'b1;
            w_state_nxt = ST_ERROR;
          end else begin
            w_wdog_nxt = r_wdog + LP_WD_ONE;
          end
        end
        ST_SHIFT_REQ: begin
          w_wdog_nxt  = LP_WD_ZERO;
          w_state_nxt = ST_SHIFT_WAIT;
        end
        ST_SHIFT_WAIT: begin
          if (iface_ack == ACK_SHIFT_FIN) begin
            w_row_done        = 1'b1;
            w_out_row_idx_nxt = r_out_cnt;
            w_out_cnt_nxt     = w_out_inc;
            if (w_out_inc >= LP_OUT_ROWS) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_LOAD_REQ;
            end
          end else if (iface_ack != ACK_IDLE) begin
            w_error_nxt = 1'b1;
            w_state_nxt = ST_ERROR;
          end else if (r_wdog >= LP_WD_LAST) begin
            w_error_nxt = 1'b1;
            w_state_nxt = ST_ERROR;
          end else begin
            w_wdog_nxt = r_wdog + LP_WD_ONE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so that every output is a flop
  // that lines up with the state it describes. busy drops in DONE so it
  // falls together with the frame_done pulse.
  always_comb begin
    w_iface_enable_nxt = 1'b0;
    w_iface_cmd_nxt    = CMD_IDLE;
    w_busy_nxt         = 1'b0;
    w_frame_done_nxt   = 1'b0;
    case (w_state_nxt)
      ST_LOAD_REQ: begin
        w_iface_enable_nxt = 1'b1;
        w_iface_cmd_nxt    = CMD_LOAD;
        w_busy_nxt         = 1'b1;
      end
      ST_SHIFT_REQ: begin
        w_iface_enable_nxt = 1'b1;
        w_iface_cmd_nxt    = CMD_SHIFT;
        w_busy_nxt         = 1'b1;
      end
      ST_LOAD_WAIT, ST_SHIFT_WAIT: begin
        w_iface_enable_nxt = 1'b1;
        w_busy_nxt         = 1'b1;
      end
      ST_DONE: begin
        w_frame_done_nxt = 1'b1;
      end
      ST_IDLE, ST_ERROR: begin
        w_iface_enable_nxt = 1'b0;
      end
      default: begin
        w_iface_enable_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_load_cnt     <= LP_ROW_ZERO;
      r_out_cnt      <= LP_ROW_ZERO;
      r_out_row_idx  <= LP_ROW_ZERO;
      r_wdog         <= LP_WD_ZERO;
      r_error        <= 1'b0;
      r_row_done     <= 1'b0;
      r_iface_enable <= 1'b0;
      r_iface_cmd    <= CMD_IDLE;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_load_cnt     <= w_load_cnt_nxt;
      r_out_cnt      <= w_out_cnt_nxt;
      r_out_row_idx  <= w_out_row_idx_nxt;
      r_wdog         <= w_wdog_nxt;
      r_error        <= w_error_nxt;
      r_row_done     <= w_row_done;
      r_iface_enable <= w_iface_enable_nxt;
      r_iface_cmd    <= w_iface_cmd_nxt;
      r_busy         <= w_busy_nxt;
      r_frame_done   <= w_frame_done_nxt;
    end
  end

  assign iface_enable = r_iface_enable;
  assign iface_cmd    = r_iface_cmd;
  assign busy         = r_busy;
  assign row_done     = r_row_done;
  assign out_row_idx  = r_out_row_idx;
  assign frame_done   = r_frame_done;
  assign error        = r_error;

endmodule

// File: tb/tb_conv_layer_row_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for conv_layer_row_sequencer. Inputs are driven and outputs sampled
// on the falling clock edge. The reference model describes a frame as
// "before computing output row r, rows 0..r+K-1 must be loaded", which
// yields the expected LOAD/SHIFT order and row indices.
// ---------------------------------------------------------------------------
module tb_conv_layer_row_sequencer;

  localparam int K        = 2;
  localparam int IMG      = 8;
  localparam int RW       = 4;
  localparam int TO       = 64;
  localparam int TW       = 7;
  localparam int OUT_ROWS = IMG - K + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [1:0]    iface_ack;
  logic          iface_enable;
  logic [1:0]    iface_cmd;
  logic          busy;
  logic          row_done;
  logic [RW-1:0] out_row_idx;
  logic          frame_done;
  logic          error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int exp_cmds[$];
  int exp_rows[$];
  int obs_cmds[$];
  int obs_rows[$];
  int obs_bad_width;
  int obs_bad_ctl;
  int obs_fd_gap;
  int obs_fd_busy;
  int obs_timed_out;
  int obs_err_cycle;
  int obs_hold_req_cycle;

  conv_layer_row_sequencer #(
    .KERNEL_SIZE(K), .IMAGE_SIZE(IMG), .ROW_CNT_WIDTH(RW),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .iface_ack(iface_ack),
    .iface_enable(iface_enable), .iface_cmd(iface_cmd), .busy(busy),
    .row_done(row_done), .out_row_idx(out_row_idx), .frame_done(frame_done),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Reference frame: load rows on demand, one shift per output row (2=L, 1=S).
  function automatic void build_model();
    int loaded = 0;
    exp_cmds.delete();
    exp_rows.delete();
    for (int r = 0; r < OUT_ROWS; r++) begin
      while (loaded < r + K) begin
        exp_cmds.push_back(2);
        loaded++;
      end
      exp_cmds.push_back(1);
      exp_rows.push_back(r);
    end
  endfunction

  function automatic int cmd_diffs();
    int d = 0;
    if (obs_cmds.size() != exp_cmds.size()) d++;
    for (int i = 0; i < obs_cmds.size() && i < exp_cmds.size(); i++)
      if (obs_cmds[i] != exp_cmds[i]) d++;
    return d;
  endfunction

  function automatic int row_diffs();
    int d = 0;
    if (obs_rows.size() != exp_rows.size()) d++;
    for (int i = 0; i < obs_rows.size() && i < exp_rows.size(); i++)
      if (obs_rows[i] != exp_rows[i]) d++;
    return d;
  endfunction

  // Interface responder: issues start, acks every command dly cycles after
  // its REQ cycle (random 1..20 when dly is 0) and records what it sees.
  // abort_shift: abort together with that SHIFT ack; hold_load: never ack
  // that LOAD; stop_shift: return in the first wait cycle of that SHIFT.
  task automatic play_frame(input int dly, input int abort_shift, input int hold_load,
                            input int stop_shift, input bit noisy);
    int n_load = 0;
    int n_shift = 0;
    int ack_at = -1;
    int last_ack = -1;
    logic [1:0] ack_code = 2'd0;
    logic [1:0] prev_cmd = 2'd0;
    bit in_wait = 1'b0;
    bit stop_now = 1'b0;
    bit did_abort = 1'b0;
    bit finished = 1'b0;
    obs_cmds.delete();
    obs_rows.delete();
    obs_bad_width = 0; obs_bad_ctl = 0; obs_fd_gap = -1; obs_fd_busy = -1;
    obs_timed_out = 0; obs_err_cycle = -1; obs_hold_req_cycle = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 3000 && !finished; b++) begin
      if (stop_now || did_abort) begin
        finished = 1'b1;
      end else if (frame_done === 1'b1) begin
        if (row_done === 1'b1) obs_rows.push_back(int'(out_row_idx));
        obs_fd_gap  = cyc - last_ack;
        obs_fd_busy = int'(busy);
        finished    = 1'b1;
      end else if (error === 1'b1) begin
        obs_err_cycle = cyc;
        finished      = 1'b1;
      end else begin
        if (row_done === 1'b1) obs_rows.push_back(int'(out_row_idx));
        if (iface_cmd !== 2'd0) begin
          obs_cmds.push_back(int'(iface_cmd));
          if (prev_cmd !== 2'd0) obs_bad_width++;
          if (iface_enable !== 1'b1 || busy !== 1'b1) obs_bad_ctl++;
          in_wait  = 1'b1;
          ack_code = (iface_cmd == 2'd2) ? 2'd2 : 2'd1;
          if (iface_cmd == 2'd2) n_load++;
          else n_shift++;
          if (iface_cmd == 2'd2 && n_load == hold_load) begin
            ack_at = -1;
            obs_hold_req_cycle = cyc;
          end else begin
            ack_at = cyc + ((dly > 0) ? dly : int'($urandom_range(1, 20)));
          end
          if (iface_cmd == 2'd1 && n_shift == stop_shift) stop_now = 1'b1;
        end else if (in_wait && (iface_enable !== 1'b1 || busy !== 1'b1)) begin
          obs_bad_ctl++;
        end
        prev_cmd  = iface_cmd;
        iface_ack = 2'd0;
        start     = (noisy && ($urandom_range(0, 5) == 0)) ? 1'b1 : 1'b0;
        if (cyc == ack_at) begin
          iface_ack = ack_code;
          in_wait   = 1'b0;
          ack_at    = -1;
          if (ack_code == 2'd1) begin
            last_ack = cyc;
            if (n_shift == abort_shift) begin
              abort     = 1'b1;
              did_abort = 1'b1;
            end
          end
        end
        tick();
      end
    end
    if (!finished) obs_timed_out = 1;
    start     = 1'b0;
    iface_ack = 2'd0;
    abort     = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] snap;
    tick(); tick();
    snap = {iface_enable, iface_cmd, busy, row_done, out_row_idx, frame_done, error};
    n_tests++;
    if (snap !== 11'd0) begin n_fail++; $display("FAIL reset_outputs: got %b want 0", snap); end
    rst = 1'b0;
    tick();
    iface_ack = 2'd3;
    tick();
    iface_ack = 2'd2;
    tick();
    iface_ack = 2'd0;
    tick();
    n_tests++;
    if (error !== 1'b0 || busy !== 1'b0 || iface_cmd !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: got err=%b busy=%b cmd=%0d want 0 0 0", error, busy, iface_cmd);
    end
  endtask

  task automatic check_full_frame(input string tag);
    n_tests++;
    if (obs_timed_out != 0 || cmd_diffs() != 0) begin
      n_fail++;
      $display("FAIL %s_cmd_order: got %0d cmds (%0d diffs, timeout=%0d) want %0d",
               tag, obs_cmds.size(), cmd_diffs(), obs_timed_out, exp_cmds.size());
    end
    n_tests++;
    if (row_diffs() != 0) begin
      n_fail++;
      $display("FAIL %s_row_idx: got %0d rows (%0d diffs) want %0d", tag, obs_rows.size(), row_diffs(), OUT_ROWS);
    end
    n_tests++;
    if (obs_fd_gap != 1) begin n_fail++; $display("FAIL %s_frame_done_gap: got %0d want 1", tag, obs_fd_gap); end
  endtask

  task automatic test_nominal();
    play_frame(10, 0, 0, 0, 1'b0);
    check_full_frame("nominal");
    n_tests++;
    if (obs_fd_busy != 0) begin n_fail++; $display("FAIL nominal_busy_at_fd: got %0d want 0", obs_fd_busy); end
    n_tests++;
    if (obs_bad_width != 0) begin n_fail++; $display("FAIL cmd_pulse_width: got %0d wide cmds want 0", obs_bad_width); end
    n_tests++;
    if (obs_bad_ctl != 0) begin n_fail++; $display("FAIL nominal_enable_busy: got %0d bad cycles want 0", obs_bad_ctl); end
    tick();
    n_tests++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || iface_enable !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_after_frame: got fd=%b busy=%b en=%b err=%b want 0", frame_done, busy, iface_enable, error);
    end
  endtask

  task automatic test_wrong_ack();
    logic [1:0] code;
    code = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (iface_cmd !== 2'd2) begin n_fail++; $display("FAIL first_cmd_load: got %0d want 2", iface_cmd); end
    tick();
    iface_ack = code;
    start     = 1'b1;
    tick();
    iface_ack = 2'd0;
    start     = 1'b0;
    n_tests++;
    if ({error, iface_enable, busy, row_done, iface_cmd} !== 6'b100000) begin
      n_fail++;
      $display("FAIL wrong_ack_%0d: got err=%b en=%b busy=%b rd=%b cmd=%0d want 1 0 0 0 0",
               code, error, iface_enable, busy, row_done, iface_cmd);
    end
    iface_ack = 2'd2;
    tick();
    iface_ack = 2'd0;
    tick();
    n_tests++;
    if (error !== 1'b1 || busy !== 1'b0 || iface_cmd !== 2'd0) begin
      n_fail++;
      $display("FAIL error_sticky: got err=%b busy=%b cmd=%0d want 1 0 0", error, busy, iface_cmd);
    end
    play_frame(0, 0, 0, 0, 1'b0);
    n_tests++;
    if (obs_err_cycle != -1) begin n_fail++; $display("FAIL restart_clears_error: got err at cycle %0d want none", obs_err_cycle); end
    check_full_frame("after_error");
    tick();
  endtask

  task automatic test_timeout();
    play_frame(0, 0, 3, 0, 1'b0);
    n_tests++;
    if (obs_err_cycle < 0 || obs_err_cycle - (obs_hold_req_cycle + 1) != TO) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d want %0d", obs_err_cycle - (obs_hold_req_cycle + 1), TO);
    end
    n_tests++;
    if (obs_cmds.size() != 4 || obs_cmds[0] != exp_cmds[0] || obs_cmds[1] != exp_cmds[1] ||
        obs_cmds[2] != exp_cmds[2] || obs_cmds[3] != exp_cmds[3]) begin
      n_fail++;
      $display("FAIL timeout_cmds: got %0d cmds want 4 (L,L,S,L)", obs_cmds.size());
    end
    n_tests++;
    if (busy !== 1'b0 || iface_enable !== 1'b0 || iface_cmd !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_outputs: got busy=%b en=%b cmd=%0d want 0 0 0", busy, iface_enable, iface_cmd);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_keeps_error: got err=%b busy=%b want 1 0", error, busy);
    end
    tick();
  endtask

  task automatic test_abort();
    play_frame(0, 2, 0, 0, 1'b0);
    n_tests++;
    if (obs_rows.size() != 1 || obs_rows[0] != 0) begin
      n_fail++;
      $display("FAIL abort_rows_before: got %0d rows want 1", obs_rows.size());
    end
    n_tests++;
    if ({row_done, frame_done, busy, iface_enable, iface_cmd, error} !== 7'd0 || out_row_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_next_cycle: got rd=%b fd=%b busy=%b en=%b cmd=%0d err=%b idx=%0d want all 0",
               row_done, frame_done, busy, iface_enable, iface_cmd, error, out_row_idx);
    end
    tick();
    play_frame(0, 0, 0, 0, 1'b0);
    check_full_frame("after_abort");
    tick();
  endtask

  task automatic test_async_reset();
    logic [10:0] snap;
    play_frame(2, 0, 0, 3, 1'b0);
    n_tests++;
    if (out_row_idx !== 4'd1 || busy !== 1'b1 || obs_rows.size() != 2) begin
      n_fail++;
      $display("FAIL pre_reset_progress: got idx=%0d busy=%b rows=%0d want 1 1 2", out_row_idx, busy, obs_rows.size());
    end
    rst = 1'b1;
    #1;
    snap = {iface_enable, iface_cmd, busy, row_done, out_row_idx, frame_done, error};
    n_tests++;
    if (snap !== 11'd0) begin n_fail++; $display("FAIL async_reset_outputs: got %b want 0", snap); end
    tick(); tick();
    rst = 1'b0;
    tick();
    play_frame(10, 0, 0, 0, 1'b0);
    check_full_frame("after_reset");
    tick();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      play_frame(0, 0, 0, 0, 1'b1);
      check_full_frame($sformatf("random%0d", f));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; iface_ack = 2'd0;
    build_model();
    test_reset();
    test_nominal();
    test_wrong_ack();
    test_timeout();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish want finish");
    $fatal(1);
  end

endmodule
